// File: rtl/spi_cmd_decoder.sv
// Frames SPI receiver bytes into EDM commands: opcode plus optional 16-bit little-endian operand.
// Range-checks operands, commits Ton/Toff/Ip/mode atomically and drives the machining run level.
module spi_cmd_decoder #(
   parameter int unsigned CLK_FREQ_HZ  = 50_000_000,
   parameter int unsigned TIMEOUT_US   = 1000,
   parameter int unsigned IP_MAX       = 200,
   parameter int unsigned TON_DEFAULT  = 100,
   parameter int unsigned TOFF_DEFAULT = 50
) (
   input  logic        clk,
   input  logic        sys_rst_n,
   input  logic [7:0]  rx_byte,
   input  logic        rx_valid,
   output logic [15:0] ton_us,
   output logic [15:0] toff_us,
   output logic [15:0] ip_set,
   output logic [1:0]  mode_sel,
   output logic        param_update,
   output logic        machine_run,
   output logic        cmd_err,
   output logic [2:0]  err_code
);

   // 64-bit product: TIMEOUT_US * CLK_FREQ_HZ overflows 32 bits at default settings
   localparam longint unsigned TO_CYC_L =
      (longint'(TIMEOUT_US) * longint'(CLK_FREQ_HZ)) / 64'd1_000_000;
   localparam int unsigned TO_CYC = 32'(TO_CYC_L);
   localparam int unsigned CNT_W  = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

   localparam logic [7:0] OP_TON   = 8'h91;
   localparam logic [7:0] OP_TOFF  = 8'h9E;
   localparam logic [7:0] OP_IP    = 8'h93;
   localparam logic [7:0] OP_MODE  = 8'h9C;
   localparam logic [7:0] OP_START = 8'h06;
   localparam logic [7:0] OP_STOP  = 8'h07;

   localparam logic [2:0] E_UNKNOWN = 3'd1;
   localparam logic [2:0] E_TIMEOUT = 3'd2;
   localparam logic [2:0] E_RANGE   = 3'd3;
   localparam logic [2:0] E_NOCFG   = 3'd4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LO   = 2'd1,
      S_HI   = 2'd2
   } state_t;

   state_t           r_state;
   logic [7:0]       r_op;
   logic [7:0]       r_lo;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_cfg_seen;

   logic [15:0]      w_operand;
   logic             w_in_range;
   logic             w_expired;

   assign w_operand = {rx_byte, r_lo};
   assign w_expired = (r_cnt == CNT_W'(TO_CYC - 1));

   // Operand legality for the latched opcode
   always_comb begin
      w_in_range = 1'b0;
      case (r_op)
         OP_TON, OP_TOFF: w_in_range = (w_operand != 16'd0);
         OP_IP:           w_in_range = (w_operand <= 16'(IP_MAX));
         OP_MODE:         w_in_range = (w_operand <= 16'd3);
         default:         w_in_range = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state      <= S_IDLE;
         r_op         <= '0;
         r_lo         <= '0;
         r_cnt        <= '0;
         r_cfg_seen   <= '0;
         ton_us       <= 16'(TON_DEFAULT);
         toff_us      <= 16'(TOFF_DEFAULT);
         ip_set       <= '0;
         mode_sel     <= '0;
         param_update <= 1'b0;
         machine_run  <= 1'b0;
         cmd_err      <= 1'b0;
         err_code     <= '0;
      end else begin
         param_update <= 1'b0;
         cmd_err      <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (rx_valid) begin
                  case (rx_byte)
                     OP_TON, OP_TOFF, OP_IP, OP_MODE: begin
                        r_op    <= rx_byte;
                        r_state <= S_LO;
                     end
                     OP_START: begin
                        // Start while running is a silent no-op
                        if (!machine_run) begin
                           if (r_cfg_seen == 3'b111) begin
                              machine_run <= 1'b1;
                           end else begin
                              cmd_err  <= 1'b1;
                              err_code <= E_NOCFG;
                           end
                        end
                     end
                     OP_STOP: machine_run <= 1'b0;
                     default: begin
                        cmd_err  <= 1'b1;
                        err_code <= E_UNKNOWN;
                     end
                  endcase
               end
            end
            S_LO: begin
               if (rx_valid) begin
                  r_lo    <= rx_byte;
                  r_cnt   <= '0;
                  r_state <= S_HI;
               end else if (w_expired) begin
                  r_cnt    <= '0;
                  r_state  <= S_IDLE;
                  cmd_err  <= 1'b1;
                  err_code <= E_TIMEOUT;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_HI: begin
               if (rx_valid) begin
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
                  if (w_in_range) begin
                     param_update <= 1'b1;
                     case (r_op)
                        OP_TON: begin
                           ton_us        <= w_operand;
                           r_cfg_seen[0] <= 1'b1;
                        end
                        OP_TOFF: begin
                           toff_us       <= w_operand;
                           r_cfg_seen[1] <= 1'b1;
                        end
                        OP_IP: begin
                           ip_set        <= w_operand;
                           r_cfg_seen[2] <= 1'b1;
                        end
                        OP_MODE: mode_sel <= w_operand[1:0];
                        default: ;
                     endcase
                  end else begin
                     cmd_err  <= 1'b1;
                     err_code <= E_RANGE;
                  end
               end else if (w_expired) begin
                  r_cnt    <= '0;
                  r_state  <= S_IDLE;
                  cmd_err  <= 1'b1;
                  err_code <= E_TIMEOUT;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
